modexp_param: RTL

- Parametrised successor of the 256-bit modular exponentiator. Computes result = base^exp mod n for any WIDTH, using right-to-left binary square-and-multiply.
- Arbitrary base values (base >= n) are accepted. Leading zero exponent bits are skipped, and the final redundant squaring is skipped.
- Uses valid/ready handshakes on input and output. Flags invalid moduli.
- Sits between the RSA key/message register file and the ciphertext output buffer. It uses one shared serial modular multiplier.

---
 rtl/rsa_pkg.sv | 41 ++++
 rtl/mod_mul_serial.sv | 66 ++++++
 rtl/modexp_param.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/rsa_pkg.sv
// Shared definitions for the modular exponentiator: FSM encoding and the
// expected input-accept to out_valid latency.
package rsa_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REDUCE = 3'd1;
  localparam logic [2:0] S_CHECK  = 3'd2;
  localparam logic [2:0] S_MUL    = 3'd3;
  localparam logic [2:0] S_SQR    = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  typedef enum logic [2:0] {
    IDLE   = S_IDLE,
    REDUCE = S_REDUCE,
    CHECK  = S_CHECK,
    MUL    = S_MUL,
    SQR    = S_SQR,
    DONE   = S_DONE
  } state_t;

  localparam int MAX_EXP_W = 1024;

  // exp=0 still costs one reduction and one check.
  function automatic int unsigned modexp_latency(input int unsigned lat_mul,
                                                 input logic [MAX_EXP_W-1:0] e);
    int unsigned pop;
    int unsigned blen;
    int unsigned steps;
    pop  = 0;
    blen = 0;
    for (int i = 0; i < MAX_EXP_W; i++) begin
      if (e[i]) begin
        pop  = pop + 1;
        blen = i + 1;
      end
    end
    steps = (blen == 0) ? 1 : blen;
    return 1 + (lat_mul + 1) * (pop + steps) + steps;
  endfunction

endpackage

// File: rtl/mod_mul_serial.sv
// Interleaved MSB-first shift-add modular multiplier: p = a*b mod n.
// Requires b < n; done pulses WIDTH+1 cycles after start.
module mod_mul_serial #(
  parameter int WIDTH = 512
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] p,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    cnt;
  logic             run;
  logic [WIDTH+1:0] n_ext;
  logic [WIDTH+1:0] r_add;
  logic [WIDTH+1:0] r_sub1;
  logic [WIDTH+1:0] r_sub2;

  // r < n and b < n keep 2r + b below 3n, so two conditional subtracts suffice.
  always_comb begin
    n_ext  = {2'b00, n};
    r_add  = {1'b0, r_q, 1'b0} + (a_sh[WIDTH-1] ? {2'b00, b_q} : '0);
    r_sub1 = (r_add >= n_ext) ? (r_add - n_ext) : r_add;
    r_sub2 = (r_sub1 >= n_ext) ? (r_sub1 - n_ext) : r_sub1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      a_sh <= '0;
      b_q  <= '0;
      r_q  <= '0;
      cnt  <= '0;
      run  <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        a_sh <= a;
        b_q  <= b;
        r_q  <= '0;
        cnt  <= CW'(WIDTH);
        run  <= 1'b1;
      end else if (run) begin
        a_sh <= a_sh << 1;
        r_q  <= r_sub2[WIDTH-1:0];
        cnt  <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign p = r_q;

endmodule

// File: rtl/modexp_param.sv
// Right-to-left square-and-multiply modular exponentiator, result = base^exp mod n,
// sharing one serial modular multiplier for reduction, multiply and square.
//
// state  | meaning
// IDLE   | in_ready, waiting for operands
// REDUCE | b_reg = base mod n via base*acc0
// CHECK  | inspect e: finish, multiply or square
// MUL    | acc = acc * b_reg
// SQR    | b_reg = b_reg^2, e >>= 1
// DONE   | out_valid held until out_ready
module modexp_param
  import rsa_pkg::*;
#(
  parameter int WIDTH     = 512,
  parameter int EXP_WIDTH = WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     base,
  input  logic [EXP_WIDTH-1:0] exp,
  input  logic [WIDTH-1:0]     n,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     result,
  output logic                 err,
  output logic                 busy
);

  state_t state, state_nx;

  logic [WIDTH-1:0]     base_q;
  logic [WIDTH-1:0]     n_q;
  logic [WIDTH-1:0]     acc_q;
  logic [WIDTH-1:0]     b_reg;
  logic [EXP_WIDTH-1:0] e_q;
  logic                 err_q;
  logic                 issued_q;

  logic                 mul_start;
  logic [WIDTH-1:0]     mul_a;
  logic [WIDTH-1:0]     mul_b;
  logic [WIDTH-1:0]     mul_p;
  logic                 mul_done;
  logic                 e_last;

  assign e_last = ((e_q >> 1) == '0);

  always_comb begin
    state_nx  = state;
    mul_start = 1'b0;
    mul_a     = '0;
    mul_b     = '0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    result    = '0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = (n == '0) ? DONE : REDUCE;
      end
      REDUCE: begin
        busy      = 1'b1;
        mul_a     = base_q;
        mul_b     = acc_q;
        mul_start = !issued_q;
        if (mul_done) state_nx = CHECK;
      end
      CHECK: begin
        busy = 1'b1;
        if (e_q == '0)  state_nx = DONE;
        else if (e_q[0]) state_nx = MUL;
        else             state_nx = SQR;
      end
      MUL: begin
        busy      = 1'b1;
        mul_a     = acc_q;
        mul_b     = b_reg;
        mul_start = !issued_q;
        if (mul_done) state_nx = e_last ? DONE : SQR;
      end
      SQR: begin
        busy      = 1'b1;
        mul_a     = b_reg;
        mul_b     = b_reg;
        mul_start = !issued_q;
        if (mul_done) state_nx = CHECK;
      end
      DONE: begin
        out_valid = 1'b1;
        err       = err_q;
        result    = err_q ? '0 : acc_q;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      base_q   <= '0;
      n_q      <= '0;
      acc_q    <= '0;
      b_reg    <= '0;
      e_q      <= '0;
      err_q    <= 1'b0;
      issued_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (mul_done)       issued_q <= 1'b0;
      else if (mul_start) issued_q <= 1'b1;
      case (state)
        IDLE: if (in_valid) begin
          base_q <= base;
          n_q    <= n;
          e_q    <= exp;
          err_q  <= (n == '0);
          acc_q  <= (n == WIDTH'(1) || n == '0) ? '0 : WIDTH'(1);
        end
        REDUCE: if (mul_done) b_reg <= mul_p;
        MUL: if (mul_done) begin
          acc_q <= mul_p;
          if (e_last) e_q <= '0;
        end
        SQR: if (mul_done) begin
          b_reg <= mul_p;
          e_q   <= e_q >> 1;
        end
        default: ;
      endcase
    end
  end

  mod_mul_serial #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start),
    .a     (mul_a),
    .b     (mul_b),
    .n     (n_q),
    .p     (mul_p),
    .done  (mul_done)
  );

endmodule
